midi_msg_decoder: RTL

Converts the raw MIDI byte stream from the UART receiver into complete, decoded MIDI messages. It drives the `midi_rdy` / `midi_cmd` / `midi_ch_sysn` / `midi_data0` / `midi_data1` bus that all sound generators and the voice allocator consume. It handles:
- running status,
- interleaved real-time bytes,
- SysEx skipping,
- Note-On-velocity-0 normalisation.

It sits between `uart_rx` and the generator bank.

---
 rtl/midi_msg_decoder_pkg.sv | 31 +++
 rtl/midi_msg_decoder_if.sv | 24 ++
 rtl/midi_msg_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/midi_msg_decoder_pkg.sv
// rtl/midi_msg_decoder_pkg.sv - shared MIDI command codes, status constants and decoder states
package midi_msg_decoder_pkg;

    localparam int MIDI_CMD_SIZE = 3;

    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF    = 3'd0;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON     = 3'd1;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_AFTERTOUCH  = 3'd2;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC          = 3'd3;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PATCH       = 3'd4;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_PRESSURE = 3'd5;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND  = 3'd6;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS         = 3'd7;

    localparam logic [7:0] MIDI_ST_SYSEX  = 8'hF0;
    localparam logic [7:0] MIDI_ST_EOX    = 8'hF7;
    localparam logic [7:0] MIDI_ST_RT_MIN = 8'hF8;

    typedef enum logic [1:0] {
        ST_NOSTAT  = 2'd0,
        ST_WAIT_D0 = 2'd1,
        ST_WAIT_D1 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_e;

    // Program change (Cx) and channel pressure (Dx) carry one data byte; the rest carry two
    function automatic logic chan_needs_two(input logic [7:0] st);
        return (st[6:4] != MIDI_CMD_PATCH) && (st[6:4] != MIDI_CMD_CH_PRESSURE);
    endfunction

endpackage

// File: rtl/midi_msg_decoder_if.sv
// rtl/midi_msg_decoder_if.sv - raw byte input and decoded message bus
interface midi_msg_decoder_if;
    import midi_msg_decoder_pkg::*;

    logic                     byte_rdy;
    logic [7:0]               byte_in;
    logic                     midi_rdy;
    logic [MIDI_CMD_SIZE-1:0] midi_cmd;
    logic [3:0]               midi_ch_sysn;
    logic [6:0]               midi_data0;
    logic [6:0]               midi_data1;
    logic                     midi_drop;
    logic                     sysex_active;

    modport master (
        output byte_rdy, byte_in,
        input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1, midi_drop, sysex_active
    );

    modport slave (
        input  byte_rdy, byte_in,
        output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1, midi_drop, sysex_active
    );
endinterface

// File: rtl/midi_msg_decoder.sv
// rtl/midi_msg_decoder.sv - MIDI byte stream to decoded message converter
module midi_msg_decoder
    import midi_msg_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    midi_msg_decoder_if.slave       bus
);

    state_e                   state_q, state_d;
    logic [7:0]               status_q, status_d;
    logic                     need2_q, need2_d;
    logic                     is_chan_q, is_chan_d;
    logic [6:0]               d0_buf_q, d0_buf_d;
    logic                     midi_rdy_q, midi_rdy_d;
    logic                     midi_drop_q, midi_drop_d;
    logic [MIDI_CMD_SIZE-1:0] cmd_q, cmd_d;
    logic [3:0]               ch_q, ch_d;
    logic [6:0]               data0_q, data0_d;
    logic [6:0]               data1_q, data1_d;

    // Register parsing context and the held message outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_NOSTAT;
            status_q    <= 8'h00;
            need2_q     <= 1'b0;
            is_chan_q   <= 1'b0;
            d0_buf_q    <= 7'h00;
            midi_rdy_q  <= 1'b0;
            midi_drop_q <= 1'b0;
            cmd_q       <= '0;
            ch_q        <= 4'h0;
            data0_q     <= 7'h00;
            data1_q     <= 7'h00;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            need2_q     <= need2_d;
            is_chan_q   <= is_chan_d;
            d0_buf_q    <= d0_buf_d;
            midi_rdy_q  <= midi_rdy_d;
            midi_drop_q <= midi_drop_d;
            cmd_q       <= cmd_d;
            ch_q        <= ch_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    // Classify each incoming byte and decide next state, context and message outputs
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        need2_d     = need2_q;
        is_chan_d   = is_chan_q;
        d0_buf_d    = d0_buf_q;
        midi_rdy_d  = 1'b0;
        midi_drop_d = 1'b0;
        cmd_d       = cmd_q;
        ch_d        = ch_q;
        data0_d     = data0_q;
        data1_d     = data1_q;

        if (bus.byte_rdy) begin
            if (bus.byte_in >= MIDI_ST_RT_MIN) begin
                // Real-time bytes pass straight through without disturbing the parse
                midi_rdy_d = 1'b1;
                cmd_d      = MIDI_CMD_SYS;
                ch_d       = bus.byte_in[3:0];
                data0_d    = 7'h00;
                data1_d    = 7'h00;
            end else if (bus.byte_in[7] && (bus.byte_in < MIDI_ST_SYSEX)) begin
                status_d  = bus.byte_in;
                need2_d   = chan_needs_two(bus.byte_in);
                is_chan_d = 1'b1;
                state_d   = ST_WAIT_D0;
            end else if (bus.byte_in[7]) begin
                // System common: running status is gone and any SysEx frame ends
                is_chan_d = 1'b0;
                case (bus.byte_in)
                    MIDI_ST_SYSEX: begin
                        status_d = 8'h00;
                        need2_d  = 1'b0;
                        state_d  = ST_SYSEX;
                    end
                    8'hF1, 8'hF3: begin
                        status_d = bus.byte_in;
                        need2_d  = 1'b0;
                        state_d  = ST_WAIT_D0;
                    end
                    8'hF2: begin
                        status_d = bus.byte_in;
                        need2_d  = 1'b1;
                        state_d  = ST_WAIT_D0;
                    end
                    8'hF6: begin
                        midi_rdy_d = 1'b1;
                        cmd_d      = MIDI_CMD_SYS;
                        ch_d       = 4'h6;
                        data0_d    = 7'h00;
                        data1_d    = 7'h00;
                        state_d    = ST_NOSTAT;
                    end
                    default: state_d = ST_NOSTAT;
                endcase
            end else begin
                case (state_q)
                    ST_NOSTAT: midi_drop_d = 1'b1;
                    ST_SYSEX:  ;
                    ST_WAIT_D0: begin
                        if (!status_q[7]) begin
                            midi_drop_d = 1'b1;
                            state_d     = ST_NOSTAT;
                        end else if (need2_q) begin
                            d0_buf_d = bus.byte_in[6:0];
                            state_d  = ST_WAIT_D1;
                        end else begin
                            midi_rdy_d = 1'b1;
                            cmd_d      = status_q[6:4];
                            ch_d       = status_q[3:0];
                            data0_d    = bus.byte_in[6:0];
                            data1_d    = 7'h00;
                            state_d    = is_chan_q ? ST_WAIT_D0 : ST_NOSTAT;
                        end
                    end
                    ST_WAIT_D1: begin
                        if (!status_q[7]) begin
                            midi_drop_d = 1'b1;
                            state_d     = ST_NOSTAT;
                        end else begin
                            midi_rdy_d = 1'b1;
                            ch_d       = status_q[3:0];
                            data0_d    = d0_buf_q;
                            data1_d    = bus.byte_in[6:0];
                            // Note-On with zero velocity is a Note-Off to every consumer
                            if ((status_q[6:4] == MIDI_CMD_NOTE_ON) && (bus.byte_in[6:0] == 7'h00))
                                cmd_d = MIDI_CMD_NOTE_OFF;
                            else
                                cmd_d = status_q[6:4];
                            state_d = is_chan_q ? ST_WAIT_D0 : ST_NOSTAT;
                        end
                    end
                    default: state_d = ST_NOSTAT;
                endcase
            end
        end
    end

    assign bus.midi_rdy     = midi_rdy_q;
    assign bus.midi_drop    = midi_drop_q;
    assign bus.midi_cmd     = cmd_q;
    assign bus.midi_ch_sysn = ch_q;
    assign bus.midi_data0   = data0_q;
    assign bus.midi_data1   = data1_q;
    assign bus.sysex_active = (state_q == ST_SYSEX);

endmodule
